// File: rtl/bmem_arbiter.sv
// rtl/bmem_arbiter.sv - icache/dcache arbiter onto a single 64-bit burst memory port
//
// Purpose:
//   Arbitrates the instruction and data caches onto one burst memory port.
//   Each 256-bit line read or write is split into four 64-bit beats.
//   Read beats are reassembled into a line before the response pulse.
//   Only one memory transaction is ever outstanding.
//
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   i_addr, i_read                    icache line read request (held until i_resp)
//   i_rdata, i_resp                   icache returned line and one-cycle completion
//   d_addr, d_read, d_write, d_wdata  dcache read / writeback request (held until d_resp)
//   d_rdata, d_resp                   dcache returned line and one-cycle completion
//   bmem_addr, bmem_read              line-aligned command address, read command
//   bmem_write, bmem_wdata            write beat valid and data
//   bmem_ready                        memory accepts the command or beat this cycle
//   bmem_raddr, bmem_rdata, bmem_rvalid  returning read beat (tag, data, valid)
//
// Build option:
//   ARB_RR_EN  defined   -> round-robin on simultaneous requests (dcache wins the first tie)
//              undefined -> fixed priority, dcache always wins ties
module bmem_arbiter #(
    parameter int LINE_BITS = 256,
    parameter int BEAT_BITS = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          i_addr,
    input  logic                 i_read,
    output logic [LINE_BITS-1:0] i_rdata,
    output logic                 i_resp,
    input  logic [31:0]          d_addr,
    input  logic                 d_read,
    input  logic                 d_write,
    input  logic [LINE_BITS-1:0] d_wdata,
    output logic [LINE_BITS-1:0] d_rdata,
    output logic                 d_resp,
    output logic [31:0]          bmem_addr,
    output logic                 bmem_read,
    output logic                 bmem_write,
    output logic [BEAT_BITS-1:0] bmem_wdata,
    input  logic                 bmem_ready,
    input  logic [31:0]          bmem_raddr,
    input  logic [BEAT_BITS-1:0] bmem_rdata,
    input  logic                 bmem_rvalid
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] RD_REQ   = 3'd1;
    localparam logic [2:0] RD_WAIT  = 3'd2;
    localparam logic [2:0] WR_BURST = 3'd3;
    localparam logic [2:0] RESP     = 3'd4;

    localparam logic [31:0] LINE_MASK = 32'hFFFF_FFE0;

    logic [2:0]                     state;
    logic [1:0]                     beat;
    logic [1:0]                     beat_next;
    logic                           owner_d;
    logic [31:0]                    line_addr;
    logic [LINE_BITS-1:0]           wdata_q;
    // Only beats 0..2 are buffered; beat 3 goes straight into the output line.
    logic [LINE_BITS-BEAT_BITS-1:0] rbuf;

    logic        i_req;
    logic        d_req;
    logic        grant_d;
    logic        grant_any;
    logic [31:0] grant_addr;
    logic        beat_hit;

    assign i_req     = i_read;
    assign d_req     = d_read | d_write;
    assign grant_any = i_req | d_req;

`ifdef ARB_RR_EN
    // 1 = dcache was granted last; resets to "icache last" so dcache wins the first tie.
    logic last_d;

    assign grant_d = d_req & (~i_req | ~last_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_d <= 1'b0;
        end else if (state == IDLE && grant_any) begin
            last_d <= grant_d;
        end
    end
`else
    assign grant_d = d_req;
`endif

    // Masking (rather than slicing) keeps every address bit in use.
    assign grant_addr = (grant_d ? d_addr : i_addr) & LINE_MASK;
    assign beat_next  = beat + 2'd1;
    // Beats tagged with another address (e.g. left over from an aborted burst) are dropped.
    assign beat_hit   = bmem_rvalid && (bmem_raddr == line_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            beat       <= 2'd0;
            owner_d    <= 1'b0;
            line_addr  <= '0;
            wdata_q    <= '0;
            rbuf       <= '0;
            i_rdata    <= '0;
            i_resp     <= 1'b0;
            d_rdata    <= '0;
            d_resp     <= 1'b0;
            bmem_addr  <= '0;
            bmem_read  <= 1'b0;
            bmem_write <= 1'b0;
            bmem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // rvalid is deliberately ignored here.
                    if (grant_any) begin
                        owner_d   <= grant_d;
                        line_addr <= grant_addr;
                        bmem_addr <= grant_addr;
                        beat      <= 2'd0;
                        // Write wins over read if the dcache raises both.
                        if (grant_d && d_write) begin
                            wdata_q    <= d_wdata;
                            bmem_write <= 1'b1;
                            bmem_wdata <= d_wdata[BEAT_BITS-1:0];
                            state      <= WR_BURST;
                        end else begin
                            bmem_read <= 1'b1;
                            state     <= RD_REQ;
                        end
                    end
                end

                RD_REQ: begin
                    if (bmem_ready) begin
                        bmem_read <= 1'b0;
                        bmem_addr <= '0;
                        state     <= RD_WAIT;
                    end
                end

                RD_WAIT: begin
                    if (beat_hit) begin
                        if (beat == 2'd3) begin
                            beat  <= 2'd0;
                            state <= RESP;
                            if (owner_d) begin
                                d_rdata <= {bmem_rdata, rbuf};
                                d_resp  <= 1'b1;
                            end else begin
                                i_rdata <= {bmem_rdata, rbuf};
                                i_resp  <= 1'b1;
                            end
                        end else begin
                            rbuf[beat*BEAT_BITS +: BEAT_BITS] <= bmem_rdata;
                            beat                              <= beat_next;
                        end
                    end
                end

                WR_BURST: begin
                    // Without ready the current beat is simply held on the bus.
                    if (bmem_ready) begin
                        if (beat == 2'd3) begin
                            beat       <= 2'd0;
                            bmem_write <= 1'b0;
                            bmem_wdata <= '0;
                            bmem_addr  <= '0;
                            d_resp     <= 1'b1;
                            state      <= RESP;
                        end else begin
                            beat       <= beat_next;
                            bmem_wdata <= wdata_q[beat_next*BEAT_BITS +: BEAT_BITS];
                        end
                    end
                end

                RESP: begin
                    i_resp <= 1'b0;
                    d_resp <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bmem_arbiter.sv
// tb/tb_bmem_arbiter.sv - scoreboard testbench for bmem_arbiter
module tb_bmem_arbiter;

    localparam int LB = 256;
    localparam int BB = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   i_addr;
    logic          i_read;
    logic [LB-1:0] i_rdata;
    logic          i_resp;
    logic [31:0]   d_addr;
    logic          d_read;
    logic          d_write;
    logic [LB-1:0] d_wdata;
    logic [LB-1:0] d_rdata;
    logic          d_resp;
    logic [31:0]   bmem_addr;
    logic          bmem_read;
    logic          bmem_write;
    logic [BB-1:0] bmem_wdata;
    logic          bmem_ready;
    logic [31:0]   bmem_raddr;
    logic [BB-1:0] bmem_rdata;
    logic          bmem_rvalid;

    bmem_arbiter #(.LINE_BITS(LB), .BEAT_BITS(BB)) dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
        .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            is_d;
        bit            is_wr;
        logic [LB-1:0] data;
    } exp_t;

    exp_t         sb[$];
    logic [63:0]  wseen[$];
    int           checks   = 0;
    int           failures = 0;

    function automatic logic [LB-1:0] rand_line();
        logic [LB-1:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom();
        return l;
    endfunction

    // Plays the memory side of one read: waits for the command, holds ready low
    // for hold_low command cycles, then returns four tagged beats (optionally with
    // a wrongly tagged beat before beat 2). Returns in the cycle after the last beat.
    task automatic serve_read(input logic [LB-1:0] line, input int hold_low, input bit junk,
                              output int wait_n, output int read_cycles,
                              output bit addr_stable, output logic [31:0] cmd_addr);
        wait_n      = 0;
        read_cycles = 0;
        addr_stable = 1'b1;
        cmd_addr    = '0;
        bmem_ready  = 1'b0;
        @(negedge clk);
        wait_n++;
        while (!bmem_read && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        if (!bmem_read) return;
        cmd_addr = bmem_addr;
        while (bmem_read && read_cycles < 20) begin
            read_cycles++;
            if (bmem_addr !== cmd_addr) addr_stable = 1'b0;
            bmem_ready = (read_cycles > hold_low);
            @(negedge clk);
        end
        for (int k = 0; k < 4; k++) begin
            if (junk && k == 2) begin
                bmem_rvalid = 1'b1;
                bmem_raddr  = cmd_addr ^ 32'h0000_0100;
                bmem_rdata  = '1;
                @(negedge clk);
            end
            bmem_rvalid = 1'b1;
            bmem_raddr  = cmd_addr;
            bmem_rdata  = line[k*BB +: BB];
            @(negedge clk);
        end
        bmem_rvalid = 1'b0;
        bmem_raddr  = '0;
        bmem_rdata  = '0;
    endtask

    // Plays the memory side of one write burst, recording every beat seen on the bus
    // and refusing beat number hold_at for hold_n cycles. Returns in the cycle after.
    task automatic serve_write(input int hold_at, input int hold_n, output logic [31:0] cmd_addr);
        int n = 0;
        int acc = 0;
        int low = 0;
        wseen.delete();
        cmd_addr   = '0;
        bmem_ready = 1'b1;
        @(negedge clk);
        n++;
        while (!bmem_write && n < 20) begin
            @(negedge clk);
            n++;
        end
        cmd_addr = bmem_addr;
        while (bmem_write && n < 40) begin
            wseen.push_back(bmem_wdata);
            if (acc == hold_at && low < hold_n) begin
                bmem_ready = 1'b0;
                low++;
            end else begin
                bmem_ready = 1'b1;
                acc++;
            end
            @(negedge clk);
            n++;
        end
        bmem_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({i_rdata, i_resp, d_rdata, d_resp, bmem_addr, bmem_read, bmem_write, bmem_wdata} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got i_resp=%b d_resp=%b bmem_read=%b bmem_write=%b bmem_addr=%h, expected all zero",
                     i_resp, d_resp, bmem_read, bmem_write, bmem_addr);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({i_resp, d_resp, bmem_read, bmem_write} !== 4'b0000) begin
            failures++;
            $display("FAIL idle_outputs: got i_resp=%b d_resp=%b bmem_read=%b bmem_write=%b, expected 0000",
                     i_resp, d_resp, bmem_read, bmem_write);
        end
    endtask

    task automatic test_icache_read();
        exp_t          e;
        int            wn, rc;
        bit            st;
        logic [31:0]   ca;
        logic [LB-1:0] line;
        line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        @(negedge clk);
        i_addr = 32'h6000_0024;
        i_read = 1'b1;
        sb.push_back('{is_d: 1'b0, is_wr: 1'b0, data: line});
        serve_read(line, 0, 1'b1, wn, rc, st, ca);
        checks++;
        if (wn !== 1 || rc !== 1) begin
            failures++;
            $display("FAIL icache_cmd_timing: got wait=%0d read_cycles=%0d, expected 1 and 1", wn, rc);
        end
        checks++;
        if (ca !== 32'h6000_0020) begin
            failures++;
            $display("FAIL icache_cmd_addr: got %h expected 60000020", ca);
        end
        e = sb.pop_front();
        checks++;
        if ({i_resp, d_resp} !== 2'b10) begin
            failures++;
            $display("FAIL icache_resp: got i_resp=%b d_resp=%b, expected 1 0", i_resp, d_resp);
        end
        checks++;
        if (i_rdata !== e.data) begin
            failures++;
            $display("FAIL icache_rdata: got %h expected %h", i_rdata, e.data);
        end
        i_read = 1'b0;
        @(negedge clk);
        checks++;
        if (i_resp !== 1'b0) begin
            failures++;
            $display("FAIL icache_resp_pulse: got i_resp=%b one cycle later, expected 0", i_resp);
        end
    endtask

    task automatic test_dcache_write();
        exp_t        e;
        logic [31:0] ca;
        int          idx[6] = '{0, 1, 2, 2, 2, 3};
        @(negedge clk);
        d_addr  = 32'h1000_0040;
        d_wdata = {64'hDDDD_0000_0000_000D, 64'hCCCC_0000_0000_000C,
                   64'hBBBB_0000_0000_000B, 64'hAAAA_0000_0000_000A};
        d_write = 1'b1;
        sb.push_back('{is_d: 1'b1, is_wr: 1'b1, data: d_wdata});
        serve_write(2, 2, ca);
        e = sb.pop_front();
        checks++;
        if (ca !== 32'h1000_0040) begin
            failures++;
            $display("FAIL write_addr: got %h expected 10000040", ca);
        end
        checks++;
        if ({d_resp, i_resp} !== 2'b10) begin
            failures++;
            $display("FAIL write_resp: got d_resp=%b i_resp=%b, expected 1 0", d_resp, i_resp);
        end
        checks++;
        if (wseen.size() !== 6) begin
            failures++;
            $display("FAIL write_beat_count: got %0d expected 6", wseen.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (wseen[k] !== e.data[idx[k]*BB +: BB]) begin
                    failures++;
                    $display("FAIL write_beat%0d: got %h expected %h", k, wseen[k], e.data[idx[k]*BB +: BB]);
                end
            end
        end
        d_write = 1'b0;
    endtask

    task automatic test_rdreq_ready_low();
        exp_t          e;
        int            wn, rc;
        bit            st;
        logic [31:0]   ca;
        logic [LB-1:0] line;
        line = rand_line();
        @(negedge clk);
        d_addr = 32'h2000_0013;
        d_read = 1'b1;
        sb.push_back('{is_d: 1'b1, is_wr: 1'b0, data: line});
        serve_read(line, 3, 1'b0, wn, rc, st, ca);
        checks++;
        if (rc !== 4 || st !== 1'b1 || ca !== 32'h2000_0000) begin
            failures++;
            $display("FAIL rdreq_hold: got read_cycles=%0d addr_stable=%b addr=%h, expected 4 1 20000000", rc, st, ca);
        end
        e = sb.pop_front();
        checks++;
        if ({d_resp, i_resp} !== 2'b10 || d_rdata !== e.data) begin
            failures++;
            $display("FAIL rdreq_resp: got d_resp=%b i_resp=%b d_rdata=%h, expected 1 0 %h", d_resp, i_resp, d_rdata, e.data);
        end
        d_read = 1'b0;
    endtask

    task automatic test_arbitration();
        exp_t          e;
        int            wn, rc;
        bit            st;
        logic [31:0]   ca, ea;
        logic [LB-1:0] line;
`ifdef ARB_RR_EN
        bit            order[3] = '{1'b1, 1'b0, 1'b1};
`else
        bit            order[3] = '{1'b1, 1'b1, 1'b0};
`endif
        rst = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        i_addr = 32'h3000_0000;
        d_addr = 32'h4000_0008;
        i_read = 1'b1;
        d_read = 1'b1;
        for (int r = 0; r < 3; r++) begin
            line = rand_line();
            ea   = (order[r] ? d_addr : i_addr) & 32'hFFFF_FFE0;
            sb.push_back('{is_d: order[r], is_wr: 1'b0, data: line});
            serve_read(line, 0, 1'b0, wn, rc, st, ca);
            checks++;
            if (ca !== ea || wn !== (r == 0 ? 1 : 2)) begin
                failures++;
                $display("FAIL arb_round%0d_grant: got addr=%h wait=%0d, expected addr=%h wait=%0d", r, ca, wn, ea, (r == 0 ? 1 : 2));
            end
            e = sb.pop_front();
            checks++;
            if ({d_resp, i_resp} !== {e.is_d, ~e.is_d} || (e.is_d ? d_rdata : i_rdata) !== e.data) begin
                failures++;
                $display("FAIL arb_round%0d_resp: got d_resp=%b i_resp=%b, expected owner_d=%b", r, d_resp, i_resp, e.is_d);
            end
            if (r == 0) d_addr = 32'h4000_0100;
            else if (order[r]) d_read = 1'b0;
            else i_read = 1'b0;
        end
    endtask

    task automatic test_d_during_i();
        exp_t          e;
        int            wn, rc;
        bit            st;
        logic [31:0]   ca;
        logic [LB-1:0] iline, dline;
        iline = rand_line();
        dline = rand_line();
        @(negedge clk);
        i_addr = 32'h5000_0008;
        i_read = 1'b1;
        sb.push_back('{is_d: 1'b0, is_wr: 1'b0, data: iline});
        fork
            begin
                repeat (4) @(negedge clk);
                d_addr = 32'h7000_0060;
                d_read = 1'b1;
                sb.push_back('{is_d: 1'b1, is_wr: 1'b0, data: dline});
            end
        join_none
        serve_read(iline, 0, 1'b0, wn, rc, st, ca);
        e = sb.pop_front();
        checks++;
        if ({i_resp, d_resp} !== 2'b10 || i_rdata !== e.data) begin
            failures++;
            $display("FAIL overlap_icache: got i_resp=%b d_resp=%b i_rdata=%h, expected 1 0 %h", i_resp, d_resp, i_rdata, e.data);
        end
        i_read = 1'b0;
        serve_read(dline, 0, 1'b0, wn, rc, st, ca);
        checks++;
        if (wn !== 2 || ca !== 32'h7000_0060) begin
            failures++;
            $display("FAIL overlap_dcache_grant: got wait=%0d addr=%h, expected 2 70000060", wn, ca);
        end
        e = sb.pop_front();
        checks++;
        if ({d_resp, i_resp} !== 2'b10 || d_rdata !== e.data) begin
            failures++;
            $display("FAIL overlap_dcache_resp: got d_resp=%b i_resp=%b d_rdata=%h, expected 1 0 %h", d_resp, i_resp, d_rdata, e.data);
        end
        d_read = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        exp_t          e;
        int            wn, rc, n;
        bit            st, bad;
        logic [31:0]   ca;
        logic [LB-1:0] line;
        line = rand_line();
        @(negedge clk);
        i_addr     = 32'h0800_0040;
        i_read     = 1'b1;
        bmem_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bmem_read && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            bmem_rvalid = 1'b1;
            bmem_raddr  = 32'h0800_0040;
            bmem_rdata  = line[k*BB +: BB];
            @(negedge clk);
        end
        bmem_rvalid = 1'b0;
        i_read      = 1'b0;
        rst         = 1'b1;
        #1;
        checks++;
        if ({i_rdata, i_resp, d_rdata, d_resp, bmem_addr, bmem_read, bmem_write, bmem_wdata} !== '0) begin
            failures++;
            $display("FAIL midburst_reset_outputs: got i_resp=%b bmem_read=%b bmem_addr=%h i_rdata=%h, expected all zero",
                     i_resp, bmem_read, bmem_addr, i_rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        bad = 1'b0;
        for (int k = 2; k < 7; k++) begin
            bmem_rvalid = (k < 4);
            bmem_raddr  = 32'h0800_0040;
            bmem_rdata  = (k < 4) ? line[k*BB +: BB] : '0;
            @(negedge clk);
            if (i_resp || d_resp || bmem_read || bmem_write) bad = 1'b1;
        end
        bmem_rvalid = 1'b0;
        checks++;
        if (bad !== 1'b0) begin
            failures++;
            $display("FAIL stale_beats: got activity=%b after reset, expected 0", bad);
        end
        line = rand_line();
        i_read = 1'b1;
        sb.push_back('{is_d: 1'b0, is_wr: 1'b0, data: line});
        serve_read(line, 0, 1'b0, wn, rc, st, ca);
        e = sb.pop_front();
        checks++;
        if (wn !== 1 || ca !== 32'h0800_0040 || i_resp !== 1'b1 || i_rdata !== e.data) begin
            failures++;
            $display("FAIL post_reset_read: got wait=%0d addr=%h i_resp=%b i_rdata=%h, expected 1 08000040 1 %h",
                     wn, ca, i_resp, i_rdata, e.data);
        end
        i_read = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        i_addr      = '0;
        i_read      = 1'b0;
        d_addr      = '0;
        d_read      = 1'b0;
        d_write     = 1'b0;
        d_wdata     = '0;
        bmem_ready  = 1'b0;
        bmem_raddr  = '0;
        bmem_rdata  = '0;
        bmem_rvalid = 1'b0;
        test_reset();
        test_icache_read();
        test_dcache_write();
        test_rdreq_ready_low();
        test_arbitration();
        test_d_during_i();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
